delivery_scheduler: RTL
=======================

Name: delivery_scheduler

Overview:
- Sequences the visited-position table for the multi-agent delivery puzzle.
- Consumes the direction byte stream and hands moves to AGENT_COUNT agents in round-robin.
- Tracks each agent's (x,y), issues one position update per move to the visited table, and counts first visits.
- Sits between the input byte decoder and the visited table; drives the final answer register.

Parameters:
POSITION_WIDTH, 12, width of each coordinate; both coordinates wrap modulo 2**POSITION_WIDTH.
AGENT_COUNT, 2, number of agents sharing the move stream; legal range 1..4.
COUNT_WIDTH, 16, width of the unique-position counter.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  input byte valid
in_data  in  8  ASCII byte
in_last  in  1  marks final byte of the stream; qualified by in_valid
in_ready  out  1  byte accepted when in_valid && in_ready
pos_change  out  1  one-cycle strobe to the visited table: write and look up pos_x/pos_y
pos_x  out  POSITION_WIDTH  agent x coordinate for this update
pos_y  out  POSITION_WIDTH  agent y coordinate for this update
lookup_valid  in  1  visited-table result strobe, fixed 2 cycles after pos_change
lookup_already_visited  in  1  1 = position seen before, 0 = first visit
unique_count  out  COUNT_WIDTH  number of distinct positions visited
result_valid  out  1  high once unique_count is final; held until reset

Behaviour:
- Reset (async, immediate): state=INIT; in_ready=0, pos_change=0, pos_x=pos_y=ORIGIN, unique_count=0, result_valid=0, turn=0, outstanding=0.
- ORIGIN = 2**(POSITION_WIDTH-1) for both coordinates. All agents start at ORIGIN.
- Reset does not clear the visited table; counts after a mid-run reset are not defined.
- FSM states:
  - INIT, first cycle after reset release: drive pos_change=1 with ORIGIN, exactly once. Next state RUN.
  - RUN: in_ready=1.
  - DRAIN: in_ready=0. Waits until outstanding==0 and pos_change==0, then goes to DONE.
  - DONE: result_valid=1, in_ready=0. Terminal until reset.
- Accepted byte in RUN:
  - '^' y+1; 'v' y-1; '>' x+1; '<' x-1. Applies to agent[turn].
  - Updated position is stored, and registered onto pos_x/pos_y with pos_change=1 on the next cycle.
  - turn advances modulo AGENT_COUNT.
  - Any other byte (e.g. 0x0A) is consumed with no pos_change and no turn advance.
- An accepted byte with in_last=1 is processed as above; the FSM then moves RUN->DRAIN.
- Throughput: one byte per cycle. in_ready is never deasserted in RUN.
- Latency:
  - byte accepted at edge t -> pos_change high in cycle t+1 -> lookup_valid in cycle t+3.
  - unique_count updates at the edge ending the lookup_valid cycle.
- Counting: unique_count += 1 on lookup_valid && !lookup_already_visited. Wraps modulo 2**COUNT_WIDTH.
- outstanding counter (width >= 2): +1 on pos_change, -1 on lookup_valid. Both in the same cycle means net 0.
- Arithmetic: coordinates wrap modulo 2**POSITION_WIDTH; no saturation, no error flag.
- in_valid is ignored outside RUN. in_last without in_valid is ignored.
- Back-to-back updates to the same address rely on the table's read-first, write-next behaviour. The second lookup returns already_visited=1; the scheduler adds no stall.

Test Plan:
- Reset, "^v", last on 'v', AGENT_COUNT=2 -> pos updates (2048,2048), (2048,2049), (2048,2047); unique_count=3; result_valid rises after drain.
- "^>v<" with last -> unique_count=3. "^v^v^v^v^v" with last -> unique_count=11.
- "^\nv" with 0x0A mid-stream -> identical pos sequence and count to "^v" (=3); newline consumes no turn.
- POSITION_WIDTH=4, AGENT_COUNT=1, twenty '>' -> x wraps 15->0; unique_count=16; pos_change count=21 including origin.
- in_valid held high during INIT and after last is accepted -> in_ready=0, no extra pos_change, count unchanged; result_valid held until reset.
- Assert reset in cycle t+2 of a run -> all outputs at reset values in the same cycle (asynchronous); INIT origin strobe reissued after release.

Source files
------------

// File: rtl/delivery_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : delivery_scheduler
//  Description : Round-robin move dispatcher for the multi-agent delivery
//                puzzle. Tracks each agent's (x,y), issues one update per
//                move to the visited table and counts first visits.
//  Revision    : 1.0 - initial release
// ============================================================================
module delivery_scheduler #(
    parameter int POSITION_WIDTH = 12,
    parameter int AGENT_COUNT    = 2,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [7:0]                in_data,
    input  logic                      in_last,
    output logic                      in_ready,
    output logic                      pos_change,
    output logic [POSITION_WIDTH-1:0] pos_x,
    output logic [POSITION_WIDTH-1:0] pos_y,
    input  logic                      lookup_valid,
    input  logic                      lookup_already_visited,
    output logic [COUNT_WIDTH-1:0]    unique_count,
    output logic                      result_valid
);

    localparam logic [POSITION_WIDTH-1:0] c_ORIGIN  = {1'b1, {(POSITION_WIDTH-1){1'b0}}};
    localparam logic [POSITION_WIDTH-1:0] c_ONE     = {{(POSITION_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [COUNT_WIDTH-1:0]    c_CNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;
    logic [POSITION_WIDTH-1:0] r_ax [AGENT_COUNT];
    logic [POSITION_WIDTH-1:0] r_ay [AGENT_COUNT];
    logic [1:0]                r_turn;
    logic [1:0]                w_turn_next;
    logic [2:0]                r_outstanding;
    logic                      r_pos_change;
    logic [POSITION_WIDTH-1:0] r_pos_x;
    logic [POSITION_WIDTH-1:0] r_pos_y;
    logic [COUNT_WIDTH-1:0]    r_count;
    logic [POSITION_WIDTH-1:0] w_cur_x;
    logic [POSITION_WIDTH-1:0] w_cur_y;
    logic [POSITION_WIDTH-1:0] w_new_x;
    logic [POSITION_WIDTH-1:0] w_new_y;
    logic                      w_is_dir;
    logic                      w_accept;
    logic                      w_move;

    assign w_accept    = (r_state == S_RUN) && in_valid;
    assign w_move      = w_accept && w_is_dir;
    assign w_turn_next = (r_turn == 2'(AGENT_COUNT - 1)) ? 2'd0 : r_turn + 2'd1;

    assign pos_change   = r_pos_change;
    assign pos_x        = r_pos_x;
    assign pos_y        = r_pos_y;
    assign unique_count = r_count;

    // Select the current agent's position and apply the decoded direction
    always_comb begin
        w_cur_x  = c_ORIGIN;
        w_cur_y  = c_ORIGIN;
        for (int i = 0; i < AGENT_COUNT; i++) begin
            if (r_turn == 2'(i)) begin
                w_cur_x = r_ax[i];
                w_cur_y = r_ay[i];
            end
        end
        w_new_x  = w_cur_x;
        w_new_y  = w_cur_y;
        w_is_dir = 1'b1;
        case (in_data)
            8'h5E:   w_new_y = w_cur_y + c_ONE;   // '^'
            8'h76:   w_new_y = w_cur_y - c_ONE;   // 'v'
            8'h3E:   w_new_x = w_cur_x + c_ONE;   // '>'
            8'h3C:   w_new_x = w_cur_x - c_ONE;   // '<'
            default: w_is_dir = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_INIT;
        else       r_state <= w_state_next;
    end

    // Next-state and state-decoded outputs
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        result_valid = 1'b0;
        case (r_state)
            S_INIT:  w_state_next = S_RUN;
            S_RUN: begin
                in_ready = 1'b1;
                if (w_accept && in_last) w_state_next = S_DRAIN;
            end
            S_DRAIN: begin
                // Every issued update must have returned its lookup result
                if (r_outstanding == 3'd0 && !r_pos_change) w_state_next = S_DONE;
            end
            S_DONE:  result_valid = 1'b1;
            default: w_state_next = S_INIT;
        endcase
    end

    // Agent positions, update strobe, turn pointer, in-flight and unique counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < AGENT_COUNT; i++) begin
                r_ax[i] <= c_ORIGIN;
                r_ay[i] <= c_ORIGIN;
            end
            r_turn        <= 2'd0;
            r_outstanding <= 3'd0;
            r_pos_change  <= 1'b0;
            r_pos_x       <= c_ORIGIN;
            r_pos_y       <= c_ORIGIN;
            r_count       <= '0;
        end else begin
            r_pos_change <= 1'b0;
            if (r_state == S_INIT) begin
                // The shared start position is registered once as visited
                r_pos_change <= 1'b1;
                r_pos_x      <= c_ORIGIN;
                r_pos_y      <= c_ORIGIN;
            end
            if (w_move) begin
                for (int i = 0; i < AGENT_COUNT; i++) begin
                    if (r_turn == 2'(i)) begin
                        r_ax[i] <= w_new_x;
                        r_ay[i] <= w_new_y;
                    end
                end
                r_pos_change <= 1'b1;
                r_pos_x      <= w_new_x;
                r_pos_y      <= w_new_y;
                r_turn       <= w_turn_next;
            end
            case ({r_pos_change, lookup_valid})
                2'b10:   r_outstanding <= r_outstanding + 3'd1;
                2'b01:   r_outstanding <= r_outstanding - 3'd1;
                default: r_outstanding <= r_outstanding;
            endcase
            if (lookup_valid && !lookup_already_visited) r_count <= r_count + c_CNT_ONE;
        end
    end

endmodule
`default_nettype wire
